// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if
//   Bundles the three requester ports and the data-memory port that surround
//   dmem_arbiter. Signal names keep their original _in/_out suffixes, seen
//   from the arbiter, so existing connection lists map one-to-one.
//
//   Parameters: DATA_W (memory word width), ADDR_W (memory address width).
//   Modports:
//     slave  - arbiter side (requests in, grants/read data/memory port out)
//     master - environment side (requesters plus the memory model)
//   Signals:
//     spi_*  : SPI loader write request, burst lock, address, data, grant
//     core_* : core request, write enable, address, write data, grant,
//              read valid, read data
//     disp_* : viewer read request, address, grant, read valid, read data
//     mem_*  : memory enable, write enable, address, write data, read data

interface dmem_arbiter_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
);

  // SPI loader
  logic              spi_req_in;
  logic              spi_lock_in;
  logic [ADDR_W-1:0] spi_addr_in;
  logic [DATA_W-1:0] spi_wdata_in;
  logic              spi_gnt_out;

  // Processor core
  logic              core_req_in;
  logic              core_we_in;
  logic [ADDR_W-1:0] core_addr_in;
  logic [DATA_W-1:0] core_wdata_in;
  logic              core_gnt_out;
  logic              core_rvalid_out;
  logic [DATA_W-1:0] core_rdata_out;

  // Seven-segment viewer
  logic              disp_req_in;
  logic [ADDR_W-1:0] disp_addr_in;
  logic              disp_gnt_out;
  logic              disp_rvalid_out;
  logic [DATA_W-1:0] disp_rdata_out;

  // Data memory port
  logic              mem_en_out;
  logic              mem_we_out;
  logic [ADDR_W-1:0] mem_addr_out;
  logic [DATA_W-1:0] mem_wdata_out;
  logic [DATA_W-1:0] mem_rdata_in;

  modport slave (
    input  spi_req_in, spi_lock_in, spi_addr_in, spi_wdata_in,
    output spi_gnt_out,
    input  core_req_in, core_we_in, core_addr_in, core_wdata_in,
    output core_gnt_out, core_rvalid_out, core_rdata_out,
    input  disp_req_in, disp_addr_in,
    output disp_gnt_out, disp_rvalid_out, disp_rdata_out,
    output mem_en_out, mem_we_out, mem_addr_out, mem_wdata_out,
    input  mem_rdata_in
  );

  modport master (
    output spi_req_in, spi_lock_in, spi_addr_in, spi_wdata_in,
    input  spi_gnt_out,
    output core_req_in, core_we_in, core_addr_in, core_wdata_in,
    input  core_gnt_out, core_rvalid_out, core_rdata_out,
    output disp_req_in, disp_addr_in,
    input  disp_gnt_out, disp_rvalid_out, disp_rdata_out,
    input  mem_en_out, mem_we_out, mem_addr_out, mem_wdata_out,
    output mem_rdata_in
  );

endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Fixed-priority arbiter sharing the single port of the 16-entry data
//   memory between the SPI data loader, the processor core and the
//   seven-segment viewer.
//
//   Priority: SPI > core > viewer. An SPI burst can hold the port with
//   spi_lock_in; while the lock register is set the core and the viewer are
//   refused even if SPI is not requesting. Grants are combinational and a
//   granted access completes in its grant cycle. Read data returns one
//   cycle after a read grant on a per-requester registered port.
//
//   Optional feature (macro DMEM_ARB_STARVE_EN):
//     defined   - a saturating 4-bit counter tracks consecutive denied viewer
//                 cycles; once it reaches STARVE_MAX the viewer outranks the
//                 core (never SPI or the lock).
//     undefined - strict SPI > core > viewer; the viewer can starve.
//
//   Parameters: DATA_W (8), ADDR_W (4), STARVE_MAX (4, range 1..15)
//   Ports:
//     clk   - clock
//     rst_n - asynchronous active-low reset; forces grants and the memory
//             port to 0 and clears lock, counter and read-return registers
//     bus   - dmem_arbiter_if.slave (requester ports and memory port)

module dmem_arbiter #(
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 4,
  parameter int STARVE_MAX = 4
) (
  input logic           clk,
  input logic           rst_n,
  dmem_arbiter_if.slave bus
);

  // Elaboration-time guard on the promotion threshold
  if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_bad_starve_max
    $error("dmem_arbiter: STARVE_MAX must be in 1..15");
  end

  logic              locked;
  logic              spi_gnt;
  logic              core_gnt;
  logic              disp_gnt;
  logic              port_busy;
  logic              promote;

  logic              core_rvalid;
  logic [DATA_W-1:0] core_rdata;
  logic              disp_rvalid;
  logic [DATA_W-1:0] disp_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;

  // ---------------------------------------------------------------------------
  // Viewer anti-starvation
  // ---------------------------------------------------------------------------
`ifdef DMEM_ARB_STARVE_EN
  logic [3:0] disp_wait;

  // Counts consecutive cycles in which the viewer asked and was refused.
  // Any viewer grant, or the viewer dropping its request, restarts the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp_wait <= '0;
    end else if (bus.disp_req_in && !disp_gnt) begin
      if (disp_wait != 4'hF) begin
        disp_wait <= disp_wait + 4'd1;
      end
    end else begin
      disp_wait <= '0;
    end
  end

  always_comb begin
    promote = (disp_wait >= 4'(STARVE_MAX));
  end
`else
  always_comb begin
    promote = 1'b0;
  end
`endif

  // ---------------------------------------------------------------------------
  // Grant logic
  // ---------------------------------------------------------------------------
  // SPI always wins when it requests, including the cycle in which its own
  // lock is expiring. The lock only shuts out the other two requesters.
  always_comb begin
    port_busy = locked | bus.spi_req_in;
    spi_gnt   = rst_n & bus.spi_req_in;
    core_gnt  = rst_n & ~port_busy & bus.core_req_in
              & ~(promote & bus.disp_req_in);
    disp_gnt  = rst_n & ~port_busy & bus.disp_req_in
              & (promote | ~bus.core_req_in);
  end

  // ---------------------------------------------------------------------------
  // Memory port mux
  // ---------------------------------------------------------------------------
  // Grants are mutually exclusive, so the if-chain order only matters for
  // readability; with no grant the port drives zeros.
  always_comb begin
    mem_en    = spi_gnt | core_gnt | disp_gnt;
    mem_we    = spi_gnt | (core_gnt & bus.core_we_in);
    mem_addr  = '0;
    mem_wdata = '0;
    if (spi_gnt) begin
      mem_addr  = bus.spi_addr_in;
      mem_wdata = bus.spi_wdata_in;
    end else if (core_gnt) begin
      mem_addr  = bus.core_addr_in;
      mem_wdata = bus.core_wdata_in;
    end else if (disp_gnt) begin
      mem_addr  = bus.disp_addr_in;
    end
  end

  // ---------------------------------------------------------------------------
  // Burst lock
  // ---------------------------------------------------------------------------
  // Set by a granted SPI access with lock asserted, held while lock stays
  // high, dropped at the first edge that sees lock low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      locked <= 1'b0;
    end else begin
      locked <= bus.spi_lock_in & (spi_gnt | locked);
    end
  end

  // ---------------------------------------------------------------------------
  // Read return
  // ---------------------------------------------------------------------------
  // rvalid pulses for one cycle after each read grant; rdata holds the last
  // returned word between reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      core_rvalid <= 1'b0;
      core_rdata  <= '0;
    end else begin
      core_rvalid <= core_gnt & ~bus.core_we_in;
      if (core_gnt && !bus.core_we_in) begin
        core_rdata <= bus.mem_rdata_in;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp_rvalid <= 1'b0;
      disp_rdata  <= '0;
    end else begin
      disp_rvalid <= disp_gnt;
      if (disp_gnt) begin
        disp_rdata <= bus.mem_rdata_in;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.spi_gnt_out     = spi_gnt;
  assign bus.core_gnt_out    = core_gnt;
  assign bus.disp_gnt_out    = disp_gnt;
  assign bus.core_rvalid_out = core_rvalid;
  assign bus.core_rdata_out  = core_rdata;
  assign bus.disp_rvalid_out = disp_rvalid;
  assign bus.disp_rdata_out  = disp_rdata;
  assign bus.mem_en_out      = mem_en;
  assign bus.mem_we_out      = mem_we;
  assign bus.mem_addr_out    = mem_addr;
  assign bus.mem_wdata_out   = mem_wdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter
//   Directed stimulus for dmem_arbiter with a per-cycle scoreboard. The
//   stimulus process pushes the hand-computed expected outputs for every
//   cycle it drives; a monitor process pops one record per falling edge and
//   compares it with what the arbiter presents. A small behavioural memory
//   sits on the memory port. The starvation section follows
//   DMEM_ARB_STARVE_EN.

module tb_dmem_arbiter;

  logic clk;
  logic rst_n;
  logic mem_init;

  dmem_arbiter_if #(.DATA_W(8), .ADDR_W(4)) bus ();

  dmem_arbiter #(.DATA_W(8), .ADDR_W(4), .STARVE_MAX(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b1;
  always #5 clk = ~clk;

  // Behavioural memory: preloaded at the first edge, then written on grant.
  logic [7:0] mem [16];
  always @(posedge clk) begin
    if (mem_init) begin
      for (int unsigned i = 0; i < 16; i++) mem[i] <= 8'h10 + 8'(i);
      mem[3] <= 8'h5A;
    end else if (bus.mem_en_out && bus.mem_we_out) begin
      mem[bus.mem_addr_out] <= bus.mem_wdata_out;
    end
  end
  assign bus.mem_rdata_in = mem[bus.mem_addr_out];

  typedef struct {
    string      name;
    logic [2:0] g;     // {spi, core, disp}
    logic       en;
    logic       we;
    logic [3:0] addr;
    logic [7:0] wd;
    logic       crv;
    logic [7:0] crd;
    logic       drv;
    logic [7:0] drd;
    logic       zrd;   // reset cycle: rdata must read 0
  } exp_t;

  exp_t exp_q [$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", n, act, req);
    end
  endtask

  // Monitor: one record per cycle, sampled mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk({e.name, "/spi_gnt"},  32'(bus.spi_gnt_out),  32'(e.g[2]));
        chk({e.name, "/core_gnt"}, 32'(bus.core_gnt_out), 32'(e.g[1]));
        chk({e.name, "/disp_gnt"}, 32'(bus.disp_gnt_out), 32'(e.g[0]));
        chk({e.name, "/mem_en"},   32'(bus.mem_en_out),   32'(e.en));
        chk({e.name, "/mem_we"},   32'(bus.mem_we_out),   32'(e.we));
        chk({e.name, "/mem_addr"}, 32'(bus.mem_addr_out), 32'(e.addr));
        chk({e.name, "/mem_wdata"},32'(bus.mem_wdata_out),32'(e.wd));
        chk({e.name, "/core_rvalid"}, 32'(bus.core_rvalid_out), 32'(e.crv));
        chk({e.name, "/disp_rvalid"}, 32'(bus.disp_rvalid_out), 32'(e.drv));
        if (e.crv || e.zrd)
          chk({e.name, "/core_rdata"}, 32'(bus.core_rdata_out), 32'(e.crd));
        if (e.drv || e.zrd)
          chk({e.name, "/disp_rdata"}, 32'(bus.disp_rdata_out), 32'(e.drd));
      end
    end
  end

  task automatic drive(input logic sr, input logic sl, input logic [3:0] sa,
                       input logic [7:0] sw, input logic cr, input logic cw,
                       input logic [3:0] ca, input logic [7:0] cd,
                       input logic dr, input logic [3:0] da);
    bus.spi_req_in    = sr;
    bus.spi_lock_in   = sl;
    bus.spi_addr_in   = sa;
    bus.spi_wdata_in  = sw;
    bus.core_req_in   = cr;
    bus.core_we_in    = cw;
    bus.core_addr_in  = ca;
    bus.core_wdata_in = cd;
    bus.disp_req_in   = dr;
    bus.disp_addr_in  = da;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 4'h0);
  endtask

  // Push expectations for the current cycle, then advance to 1 after the edge.
  task automatic cyc(input string n, input logic [2:0] g, input logic we,
                     input logic [3:0] addr, input logic [7:0] wd,
                     input logic crv, input logic [7:0] crd,
                     input logic drv, input logic [7:0] drd);
    exp_t e;
    e.name = n; e.g = g; e.en = |g; e.we = we; e.addr = addr; e.wd = wd;
    e.crv = crv; e.crd = crd; e.drv = drv; e.drd = drd; e.zrd = 1'b0;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Reset asserted mid-cycle with traffic present: everything reads 0.
  task automatic reset_cyc(input string n);
    exp_t e;
    e.name = n; e.g = 3'b000; e.en = 1'b0; e.we = 1'b0; e.addr = 4'h0;
    e.wd = 8'h00; e.crv = 1'b0; e.crd = 8'h00; e.drv = 1'b0; e.drd = 8'h00;
    e.zrd = 1'b1;
    exp_q.push_back(e);
    #2 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    exp_t e;
    mem_init = 1'b1;
    rst_n    = 1'b1;
    drive(1'b1, 1'b1, 4'h5, 8'h55, 1'b1, 1'b0, 4'h3, 8'h00, 1'b1, 4'h6);
    #1 rst_n = 1'b0;
    e.name = "init_rst"; e.g = 3'b000; e.en = 1'b0; e.we = 1'b0; e.addr = 4'h0;
    e.wd = 8'h00; e.crv = 1'b0; e.crd = 8'h00; e.drv = 1'b0; e.drd = 8'h00;
    e.zrd = 1'b1;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    rst_n    = 1'b1;
    mem_init = 1'b0;

    // Read after reset
    drive(0, 0, 4'h0, 8'h00, 1, 0, 4'h3, 8'h00, 0, 4'h0);
    cyc("rd3_gnt", 3'b010, 0, 4'h3, 8'h00, 0, 8'h00, 0, 8'h00);
    idle();
    cyc("rd3_rv",  3'b000, 0, 4'h0, 8'h00, 1, 8'h5A, 0, 8'h00);

    // Three-way contention, then core, then viewer
    drive(1, 0, 4'h9, 8'hA5, 1, 0, 4'h5, 8'h00, 1, 4'h6);
    cyc("contend",    3'b100, 1, 4'h9, 8'hA5, 0, 8'h00, 0, 8'h00);
    drive(0, 0, 4'h0, 8'h00, 1, 0, 4'h5, 8'h00, 1, 4'h6);
    cyc("core_after", 3'b010, 0, 4'h5, 8'h00, 0, 8'h00, 0, 8'h00);
    drive(0, 0, 4'h0, 8'h00, 0, 0, 4'h0, 8'h00, 1, 4'h6);
    cyc("disp_gnt",   3'b001, 0, 4'h6, 8'h00, 1, 8'h15, 0, 8'h00);
    idle();
    cyc("disp_rv",    3'b000, 0, 4'h0, 8'h00, 0, 8'h00, 1, 8'h16);

    // SPI write landed
    drive(0, 0, 4'h0, 8'h00, 1, 0, 4'h9, 8'h00, 0, 4'h0);
    cyc("rd9",    3'b010, 0, 4'h9, 8'h00, 0, 8'h00, 0, 8'h00);
    idle();
    cyc("rd9_rv", 3'b000, 0, 4'h0, 8'h00, 1, 8'hA5, 0, 8'h00);

    // Burst lock with a 2-cycle gap; core read of 12 held throughout
    drive(1, 1, 4'h0, 8'hC0, 1, 0, 4'hC, 8'h00, 0, 4'h0);
    cyc("lock_w0",   3'b100, 1, 4'h0, 8'hC0, 0, 8'h00, 0, 8'h00);
    drive(1, 1, 4'h1, 8'hC1, 1, 0, 4'hC, 8'h00, 0, 4'h0);
    cyc("lock_w1",   3'b100, 1, 4'h1, 8'hC1, 0, 8'h00, 0, 8'h00);
    drive(0, 1, 4'h0, 8'h00, 1, 0, 4'hC, 8'h00, 0, 4'h0);
    cyc("lock_gap1", 3'b000, 0, 4'h0, 8'h00, 0, 8'h00, 0, 8'h00);
    cyc("lock_gap2", 3'b000, 0, 4'h0, 8'h00, 0, 8'h00, 0, 8'h00);
    drive(1, 0, 4'h2, 8'hC2, 1, 0, 4'hC, 8'h00, 0, 4'h0);
    cyc("lock_last", 3'b100, 1, 4'h2, 8'hC2, 0, 8'h00, 0, 8'h00);
    drive(0, 0, 4'h0, 8'h00, 1, 0, 4'hC, 8'h00, 0, 4'h0);
    cyc("lock_free", 3'b010, 0, 4'hC, 8'h00, 0, 8'h00, 0, 8'h00);

    // Core write then read back
    drive(0, 0, 4'h0, 8'h00, 1, 1, 4'hC, 8'h7F, 0, 4'h0);
    cyc("wr12",    3'b010, 1, 4'hC, 8'h7F, 1, 8'h1C, 0, 8'h00);
    drive(0, 0, 4'h0, 8'h00, 1, 0, 4'hC, 8'h00, 0, 4'h0);
    cyc("rd12",    3'b010, 0, 4'hC, 8'h00, 0, 8'h00, 0, 8'h00);
    idle();
    cyc("rd12_rv", 3'b000, 0, 4'h0, 8'h00, 1, 8'h7F, 0, 8'h00);
    drive(0, 0, 4'h0, 8'h00, 1, 0, 4'h0, 8'h00, 0, 4'h0);
    cyc("rd0",     3'b010, 0, 4'h0, 8'h00, 0, 8'h00, 0, 8'h00);
    idle();
    cyc("rd0_rv",  3'b000, 0, 4'h0, 8'h00, 1, 8'hC0, 0, 8'h00);

    // Reset mid-burst drops the lock
    drive(1, 1, 4'h4, 8'h44, 0, 0, 4'h0, 8'h00, 0, 4'h0);
    cyc("burst_w4",   3'b100, 1, 4'h4, 8'h44, 0, 8'h00, 0, 8'h00);
    drive(0, 1, 4'h0, 8'h00, 1, 0, 4'h1, 8'h00, 0, 4'h0);
    cyc("burst_hold", 3'b000, 0, 4'h0, 8'h00, 0, 8'h00, 0, 8'h00);
    reset_cyc("rst_burst");
    cyc("post_rst",   3'b010, 0, 4'h1, 8'h00, 0, 8'h00, 0, 8'h00);
    drive(0, 1, 4'h0, 8'h00, 1, 0, 4'h4, 8'h00, 0, 4'h0);
    cyc("rd4",        3'b010, 0, 4'h4, 8'h00, 1, 8'hC1, 0, 8'h00);
    idle();
    cyc("rd4_rv",     3'b000, 0, 4'h0, 8'h00, 1, 8'h44, 0, 8'h00);

    // Reset with an rvalid pending
    drive(0, 0, 4'h0, 8'h00, 1, 0, 4'h3, 8'h00, 0, 4'h0);
    cyc("rd3b",       3'b010, 0, 4'h3, 8'h00, 0, 8'h00, 0, 8'h00);
    idle();
    reset_cyc("rst_rvalid");
    cyc("post_rst2",  3'b000, 0, 4'h0, 8'h00, 0, 8'h00, 0, 8'h00);

    // Core and viewer both held
    drive(0, 0, 4'h0, 8'h00, 1, 0, 4'h3, 8'h00, 1, 4'h5);
`ifdef DMEM_ARB_STARVE_EN
    for (int i = 0; i < 4; i++)
      cyc("starve_core", 3'b010, 0, 4'h3, 8'h00, (i > 0), 8'h5A, 0, 8'h00);
    cyc("starve_disp",  3'b001, 0, 4'h5, 8'h00, 1, 8'h5A, 0, 8'h00);
    cyc("starve_back",  3'b010, 0, 4'h3, 8'h00, 0, 8'h00, 1, 8'h15);
    cyc("starve_core2", 3'b010, 0, 4'h3, 8'h00, 1, 8'h5A, 0, 8'h00);
`else
    for (int i = 0; i < 50; i++)
      cyc("strict_core", 3'b010, 0, 4'h3, 8'h00, (i > 0), 8'h5A, 0, 8'h00);
`endif
    idle();
    cyc("tail", 3'b000, 0, 4'h0, 8'h00, 1, 8'h5A, 0, 8'h00);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain actual=%0d required=0", exp_q.size());
    end
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Single-port arbiter for the 16-entry data memory. It shares the port between three requesters: the SPI data loader, the processor core (accumulator store / register read) and the seven-segment viewer. It replaces the ad-hoc address/data muxing in front of the data memory with a fixed-priority scheme. The scheme adds SPI burst locking, optional viewer anti-starvation, and registered read-data return per requester.

## Interface
Parameters:
- DATA_W, 8, memory word width
- ADDR_W, 4, memory address width
- STARVE_MAX, 4, consecutive denied viewer cycles before promotion (range 1..15)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- spi_req_in / spi_lock_in  in  1 each  SPI write request; hold port for a burst
- spi_addr_in  in  ADDR_W  SPI write address
- spi_wdata_in  in  DATA_W  SPI write data
- spi_gnt_out  out  1  SPI granted this cycle
- core_req_in / core_we_in  in  1 each  core request; 1 = write, 0 = read
- core_addr_in  in  ADDR_W  core address
- core_wdata_in  in  DATA_W  core write data
- core_gnt_out  out  1  core granted; low means the core must stall
- core_rvalid_out  out  1  core read data valid
- core_rdata_out  out  DATA_W  core read data
- disp_req_in  in  1  viewer read request
- disp_addr_in  in  ADDR_W  viewer address
- disp_gnt_out / disp_rvalid_out  out  1 each  viewer grant / read valid
- disp_rdata_out  out  DATA_W  viewer read data
- mem_en_out / mem_we_out  out  1 each  memory access / write enable
- mem_addr_out  out  ADDR_W  memory address
- mem_wdata_out  out  DATA_W  memory write data
- mem_rdata_in  in  DATA_W  memory read data; combinational from mem_addr_out

## Operation
- Grants are combinational from the requests and the registered state. At most one grant is high per cycle.
- Base priority is SPI > core > viewer. A granted access completes in its grant cycle.
- Memory port mux:
  - mem_addr_out, mem_wdata_out follow the granted requester.
  - mem_en_out = any grant.
  - mem_we_out = spi_gnt | (core_gnt & core_we_in).
  - The viewer never writes.
  - With no grant, mem_addr_out = 0 and mem_wdata_out = 0.
- Lock register `locked`:
  - next value = (spi_gnt & spi_lock_in) | (locked & spi_lock_in).
  - While locked=1, core_gnt and disp_gnt are forced 0, even with spi_req_in low; the port idles.
  - locked clears at the first edge that samples spi_lock_in=0.
- Starvation counter `disp_wait` (4 bits):
  - Increments, saturating at 15, on every cycle with disp_req_in & ~disp_gnt_out.
  - Clears on disp_gnt_out or ~disp_req_in.
  - When disp_wait >= STARVE_MAX, the viewer outranks the core for that cycle; it never outranks SPI or the lock.
- Read return:
  - On a core read grant, core_rdata_out <= mem_rdata_in and core_rvalid_out <= 1 at the next edge; otherwise core_rvalid_out <= 0 and core_rdata_out holds.
  - disp_rvalid_out / disp_rdata_out behave the same way on a viewer grant.
- Core writes produce no rvalid.

## Timing
- Reset (rst_n=0, async): locked=0, disp_wait=0, both rvalid=0, both rdata=0. All grants and mem_* outputs are forced 0 while rst_n=0.
- Request to grant: 0 cycles. Read grant to rvalid/rdata: 1 cycle. Write grant to memory update: the same edge.
- rvalid is a single-cycle pulse per granted read. Back-to-back grants give back-to-back rvalid.
- Requesters hold req/addr/wdata until they see their grant. Changing them before grant is allowed and is simply re-arbitrated.
- Simultaneous spi_req and expiry of the lock in the same cycle: spi_req is still granted through normal priority.
- Reset asserted mid-burst drops the lock and any pending rvalid immediately.

## Configuration
- DMEM_ARB_STARVE_EN defined: the disp_wait counter and viewer promotion are present as described.
- DMEM_ARB_STARVE_EN undefined: the counter is removed and priority is strictly SPI > core > viewer. A viewer may then wait indefinitely while the core requests continuously.

## Test plan
- Reset: drive rst_n=0 mid-traffic -> all outputs 0 in the same cycle. After release, core read of addr 3 (mem holds 0x5A) -> core_gnt=1, next cycle core_rvalid=1, core_rdata=0x5A.
- Contention: spi, core and disp requests all high for one cycle -> only spi_gnt=1; mem_we=1 at spi_addr. Next cycle, with spi_req low -> core_gnt=1.
- Lock: spi_lock=1 with spi writes to 0,1, a 2-cycle gap, then 2 -> core_req held high gets no grant. core_gnt=1 first in the cycle after the edge sampling spi_lock=0.
- Starvation (macro on, STARVE_MAX=4): core_req and disp_req held high -> core granted 4 cycles, disp_gnt=1 on cycle 5, disp_rvalid on cycle 6, then core again.
- Macro off, same stimulus over 50 cycles -> disp_gnt never asserts.
- Core write then read: write 0x7F to addr 12, read addr 12 the next cycle -> core_rdata=0x7F with rvalid.
